// File: rtl/pkg_spi_ctrl.sv
// Shared definitions for the SPI transfer controller: FSM states,
// control-word field layout and SPI byte width.
package pkg_spi_ctrl;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_STORE,
    ST_NEXT,
    ST_DONE
  } state_e;

  localparam int CTRL_SEND_BIT = 0;
  localparam int CTRL_CS_BIT   = 1;
  localparam int CTRL_ALL1_BIT = 2;
  localparam int CTRL_ALL0_BIT = 3;
  localparam int CTRL_NTX_LSB  = 4;
  localparam int CTRL_NTX_W    = 9;
  localparam int CTRL_NRX_LSB  = 16;
  localparam int CTRL_NRX_W    = 10;
  localparam int CTRL_ERR_BIT  = 31;

  localparam int SPI_BYTE_W    = 8;

endpackage

// File: rtl/module_control_spi.sv
// Walks the data entries of a small register file, sends one byte per entry
// over an SPI master and writes each received byte back in place.
module module_control_spi
  import pkg_spi_ctrl::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] ctrl_i,
  output logic                  ctrl_wr_o,
  output logic [DATA_WIDTH-1:0] ctrl_o,
  output logic [N-1:0]          data_addr_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  data_wr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  hold_ctrl_o,
  output logic                  spi_start_o,
  output logic [SPI_BYTE_W-1:0] spi_tx_o,
  input  logic [SPI_BYTE_W-1:0] spi_rx_i,
  input  logic                  spi_done_i,
  output logic                  cs_o,
  output logic                  busy_o
);

  localparam int MAX_TX = (1 << N) - 1;
  localparam int TXW    = CTRL_NTX_W + 1;

  state_e                state_q, state_d;
  logic [N-1:0]          k_q, k_d;
  logic                  cs_q, cs_d;
  logic [N-1:0]          kPlus1;
  logic [TXW-1:0]        txTotal;
  logic                  txClamped;
  logic [N-1:0]          txCount;
  logic [DATA_WIDTH-1:0] ctrlErr;
  logic                  unusedDataBits;

  assign unusedDataBits = ^data_i[DATA_WIDTH-1:SPI_BYTE_W];

  // Entry 0 is the control word, so at most 2^N-1 data entries can be walked.
  always_comb begin
    txTotal   = {1'b0, ctrl_i[CTRL_NTX_LSB +: CTRL_NTX_W]} + TXW'(1);
    txClamped = txTotal > TXW'(MAX_TX);
    txCount   = txClamped ? N'(MAX_TX) : txTotal[N-1:0];
    kPlus1    = k_q + N'(1);
    ctrlErr   = ctrl_i;
    ctrlErr[CTRL_ERR_BIT] = ctrl_i[CTRL_ERR_BIT] | txClamped;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      cs_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cs_q    <= cs_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    ctrl_wr_o   = 1'b0;
    ctrl_o      = '0;
    data_wr_o   = 1'b0;
    data_o      = '0;
    spi_start_o = 1'b0;
    spi_tx_o    = '0;
    busy_o      = (state_q != ST_IDLE);
    hold_ctrl_o = (state_q != ST_IDLE);
    data_addr_o = (state_q != ST_IDLE) ? kPlus1 : '0;

    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_i[CTRL_SEND_BIT]) begin
          state_d = ST_LOAD;
          k_d     = '0;
        end
      end
      ST_LOAD: state_d = ST_START;
      ST_START: begin
        spi_start_o = 1'b1;
        if (ctrl_i[CTRL_ALL1_BIT])      spi_tx_o = '1;
        else if (ctrl_i[CTRL_ALL0_BIT]) spi_tx_o = '0;
        else                            spi_tx_o = data_i[SPI_BYTE_W-1:0];
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (spi_done_i) state_d = ST_STORE;
      end
      ST_STORE: begin
        data_wr_o = 1'b1;
        data_o    = DATA_WIDTH'(spi_rx_i);
        ctrl_wr_o = 1'b1;
        ctrl_o    = ctrlErr;
        ctrl_o[CTRL_NRX_LSB +: CTRL_NRX_W] = CTRL_NRX_W'(kPlus1);
        state_d   = ST_NEXT;
      end
      ST_NEXT: begin
        if (kPlus1 == txCount) begin
          state_d = ST_DONE;
        end else begin
          k_d     = kPlus1;
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        ctrl_wr_o = 1'b1;
        ctrl_o    = ctrlErr;
        ctrl_o[CTRL_SEND_BIT] = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Chip select follows cs_ctrl until the first START, then stays low to DONE.
    if (state_d == ST_IDLE || (state_d == ST_LOAD && state_q == ST_IDLE))
      cs_d = ~ctrl_i[CTRL_CS_BIT];
    else
      cs_d = 1'b0;
  end

  assign cs_o = cs_q;

endmodule

// File: tb/tb_module_control_spi.sv
// Scoreboard bench for module_control_spi: a register-file model, an SPI
// slave model, and a monitor that checks every strobe against expected events.
module tb_module_control_spi;
  import pkg_spi_ctrl::*;

  localparam int DW = 32;
  localparam int NA = 2;
  localparam logic [1:0] K_START = 2'd0;
  localparam logic [1:0] K_DATA  = 2'd1;
  localparam logic [1:0] K_CTRL  = 2'd2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [DW-1:0] ctrl_i;
  logic          ctrl_wr_o;
  logic [DW-1:0] ctrl_o;
  logic [NA-1:0] data_addr_o;
  logic [DW-1:0] data_i;
  logic          data_wr_o;
  logic [DW-1:0] data_o;
  logic          hold_ctrl_o;
  logic          spi_start_o;
  logic [7:0]    spi_tx_o;
  logic [7:0]    spi_rx_i;
  logic          spi_done_i;
  logic          cs_o;
  logic          busy_o;

  logic [DW-1:0] regs [0:(1<<NA)-1];
  logic          tbWr;
  logic [NA-1:0] tbAddr;
  logic [DW-1:0] tbData;
  logic          slaveEn;
  logic [7:0]    rxQ [$];
  logic [39:0]   expQ [$];
  int            checks = 0;
  int            errors = 0;

  module_control_spi #(.DATA_WIDTH(DW), .N(NA)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ctrl_i(ctrl_i), .ctrl_wr_o(ctrl_wr_o),
    .ctrl_o(ctrl_o), .data_addr_o(data_addr_o), .data_i(data_i),
    .data_wr_o(data_wr_o), .data_o(data_o), .hold_ctrl_o(hold_ctrl_o),
    .spi_start_o(spi_start_o), .spi_tx_o(spi_tx_o), .spi_rx_i(spi_rx_i),
    .spi_done_i(spi_done_i), .cs_o(cs_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  assign ctrl_i = regs[0];
  assign data_i = regs[data_addr_o];

  // Register file: DUT write ports plus a bench port whose entry-0 writes obey hold.
  always @(posedge clk_i) begin
    if (ctrl_wr_o) regs[0] <= ctrl_o;
    else if (tbWr && tbAddr == '0 && !hold_ctrl_o) regs[0] <= tbData;
    if (data_wr_o) regs[data_addr_o] <= data_o;
    else if (tbWr && tbAddr != '0) regs[tbAddr] <= tbData;
  end

  function automatic logic [39:0] ev(input logic [1:0] kind, input logic [5:0] addr,
                                     input logic [31:0] value);
    return {kind, addr, value};
  endfunction

  task automatic checkOutput(input string name, input logic [39:0] actual,
                             input logic [39:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%010h, expected 0x%010h", name, actual, expected);
    end
  endtask

  task automatic popCheck(input string name, input logic [39:0] actual);
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: got unexpected event 0x%010h, expected none", name, actual);
    end else begin
      checkOutput(name, actual, expQ.pop_front());
    end
  endtask

  // Monitor: every strobe the DUT raises must match the next expected event.
  initial forever begin
    @(negedge clk_i);
    if (spi_start_o) popCheck("spi_start", ev(K_START, 6'd0, {24'd0, spi_tx_o}));
    if (data_wr_o)   popCheck("data_wr", ev(K_DATA, 6'(data_addr_o), data_o));
    if (ctrl_wr_o)   popCheck("ctrl_wr", ev(K_CTRL, 6'd0, ctrl_o));
  end

  // SPI slave model: answers each start two cycles later with the next rx byte.
  initial begin
    logic [7:0] b;
    spi_rx_i   = '0;
    spi_done_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (spi_start_o && slaveEn) begin
        b = (rxQ.size() > 0) ? rxQ.pop_front() : 8'h00;
        repeat (2) @(negedge clk_i);
        spi_rx_i   = b;
        spi_done_i = 1'b1;
        @(negedge clk_i);
        spi_done_i = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic extWrite(input logic [NA-1:0] a, input logic [DW-1:0] d);
    @(negedge clk_i);
    tbWr = 1'b1; tbAddr = a; tbData = d;
    @(negedge clk_i);
    tbWr = 1'b0;
  endtask

  task automatic waitBusy(input logic want, input int limit, input string name);
    int n;
    n = 0;
    while (busy_o !== want && n < limit) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput(name, {39'd0, busy_o}, {39'd0, want});
  endtask

  task automatic applyStimulus(input logic [DW-1:0] ctrl, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
    extWrite(2'd1, {24'd0, e1});
    extWrite(2'd2, {24'd0, e2});
    extWrite(2'd3, {24'd0, e3});
    extWrite(2'd0, ctrl);
    waitBusy(1'b1, 10, "busy_rise");
    waitBusy(1'b0, 200, "busy_fall");
    checkOutput("scoreboard_drained", 40'(expQ.size()), 40'd0);
  endtask

  initial begin
    int n;
    rst_i = 1'b0; tbWr = 1'b0; tbAddr = '0; tbData = '0; slaveEn = 1'b1;
    for (int i = 0; i < 4; i++) extWrite(NA'(i), '0);
    checkOutput("rst_cs", {39'd0, cs_o}, 40'd1);
    checkOutput("rst_busy_hold", {38'd0, busy_o, hold_ctrl_o}, 40'd0);
    checkOutput("rst_strobes", {37'd0, ctrl_wr_o, data_wr_o, spi_start_o}, 40'd0);
    checkOutput("rst_addr", 40'(data_addr_o), 40'd0);
    @(negedge clk_i); rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    checkOutput("idle_cs_high", {39'd0, cs_o}, 40'd1);

    // Single transfer with send-to-start latency checks.
    rxQ.push_back(8'hA5);
    expQ.push_back(ev(K_START, 0, 32'h25));
    expQ.push_back(ev(K_DATA, 1, 32'hA5));
    expQ.push_back(ev(K_CTRL, 0, 32'h0001_0001));
    expQ.push_back(ev(K_CTRL, 0, 32'h0001_0000));
    extWrite(2'd1, 32'h25);
    extWrite(2'd0, 32'h1);
    checkOutput("lat_cycle0_start", {39'd0, spi_start_o}, 40'd0);
    @(negedge clk_i);
    checkOutput("lat_cycle1_start", {39'd0, spi_start_o}, 40'd0);
    checkOutput("load_busy_hold", {38'd0, busy_o, hold_ctrl_o}, 40'd3);
    checkOutput("load_addr", 40'(data_addr_o), 40'd1);
    @(negedge clk_i);
    checkOutput("lat_cycle2_start", {39'd0, spi_start_o}, 40'd1);
    checkOutput("start_cs_low", {39'd0, cs_o}, 40'd0);
    waitBusy(1'b0, 200, "t1_busy_fall");
    checkOutput("t1_entry1", {8'd0, regs[1]}, 40'h0000_00A5);
    checkOutput("t1_ctrl", {8'd0, regs[0]}, 40'h0001_0000);
    checkOutput("t1_cs_idle", {39'd0, cs_o}, 40'd1);
    checkOutput("t1_drained", 40'(expQ.size()), 40'd0);

    // Three transfers walking entries 1..3.
    rxQ.push_back(8'hB1); rxQ.push_back(8'hB2); rxQ.push_back(8'hB3);
    expQ.push_back(ev(K_START, 0, 32'h11));
    expQ.push_back(ev(K_DATA, 1, 32'hB1));
    expQ.push_back(ev(K_CTRL, 0, 32'h0001_0021));
    expQ.push_back(ev(K_START, 0, 32'h22));
    expQ.push_back(ev(K_DATA, 2, 32'hB2));
    expQ.push_back(ev(K_CTRL, 0, 32'h0002_0021));
    expQ.push_back(ev(K_START, 0, 32'h33));
    expQ.push_back(ev(K_DATA, 3, 32'hB3));
    expQ.push_back(ev(K_CTRL, 0, 32'h0003_0021));
    expQ.push_back(ev(K_CTRL, 0, 32'h0003_0020));
    applyStimulus(32'h21, 8'h11, 8'h22, 8'h33);
    checkOutput("t2_entries", {16'd0, regs[1][7:0], regs[2][7:0], regs[3][7:0]}, 40'hB1B2B3);
    checkOutput("t2_ctrl", {8'd0, regs[0]}, 40'h0003_0020);

    // all_1s wins over all_0s, then all_0s alone.
    rxQ.push_back(8'h3C);
    expQ.push_back(ev(K_START, 0, 32'hFF));
    expQ.push_back(ev(K_DATA, 1, 32'h3C));
    expQ.push_back(ev(K_CTRL, 0, 32'h0001_000D));
    expQ.push_back(ev(K_CTRL, 0, 32'h0001_000C));
    applyStimulus(32'h0D, 8'h5A, 8'h00, 8'h00);
    rxQ.push_back(8'h01);
    expQ.push_back(ev(K_START, 0, 32'h00));
    expQ.push_back(ev(K_DATA, 1, 32'h01));
    expQ.push_back(ev(K_CTRL, 0, 32'h0001_0009));
    expQ.push_back(ev(K_CTRL, 0, 32'h0001_0008));
    applyStimulus(32'h09, 8'h77, 8'h00, 8'h00);

    // n_tx_end=5 clamps to three transfers and flags err.
    rxQ.push_back(8'hC1); rxQ.push_back(8'hC2); rxQ.push_back(8'hC3);
    expQ.push_back(ev(K_START, 0, 32'hA1));
    expQ.push_back(ev(K_DATA, 1, 32'hC1));
    expQ.push_back(ev(K_CTRL, 0, 32'h8001_0051));
    expQ.push_back(ev(K_START, 0, 32'hA2));
    expQ.push_back(ev(K_DATA, 2, 32'hC2));
    expQ.push_back(ev(K_CTRL, 0, 32'h8002_0051));
    expQ.push_back(ev(K_START, 0, 32'hA3));
    expQ.push_back(ev(K_DATA, 3, 32'hC3));
    expQ.push_back(ev(K_CTRL, 0, 32'h8003_0051));
    expQ.push_back(ev(K_CTRL, 0, 32'h8003_0050));
    applyStimulus(32'h51, 8'hA1, 8'hA2, 8'hA3);
    checkOutput("t4_ctrl", {8'd0, regs[0]}, 40'h8003_0050);

    // Reset while waiting on the SPI master.
    slaveEn = 1'b0;
    expQ.push_back(ev(K_START, 0, 32'h44));
    extWrite(2'd1, 32'h44);
    extWrite(2'd0, 32'h1);
    n = 0;
    while (spi_start_o !== 1'b1 && n < 10) begin @(negedge clk_i); n++; end
    checkOutput("t5_reached_start", {39'd0, spi_start_o}, 40'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checkOutput("t5_rst_busy_hold", {38'd0, busy_o, hold_ctrl_o}, 40'd0);
    checkOutput("t5_rst_cs", {39'd0, cs_o}, 40'd1);
    checkOutput("t5_rst_strobes", {37'd0, ctrl_wr_o, data_wr_o, spi_start_o}, 40'd0);
    extWrite(2'd0, 32'h0);
    @(negedge clk_i); rst_i = 1'b1;
    @(negedge clk_i); spi_rx_i = 8'h99; spi_done_i = 1'b1;
    @(negedge clk_i); spi_done_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checkOutput("t5_idle_after_done", {39'd0, busy_o}, 40'd0);
    checkOutput("t5_entry1_kept", {8'd0, regs[1]}, 40'h44);
    checkOutput("t5_ctrl", {8'd0, regs[0]}, 40'h0);
    checkOutput("t5_drained", 40'(expQ.size()), 40'd0);

    // cs_ctrl while idle, and an external ctrl write blocked during busy.
    slaveEn = 1'b1;
    extWrite(2'd0, 32'h2);
    @(negedge clk_i);
    checkOutput("t6_idle_cs_low", {39'd0, cs_o}, 40'd0);
    rxQ.push_back(8'h6D);
    expQ.push_back(ev(K_START, 0, 32'h5C));
    expQ.push_back(ev(K_DATA, 1, 32'h6D));
    expQ.push_back(ev(K_CTRL, 0, 32'h0001_0003));
    expQ.push_back(ev(K_CTRL, 0, 32'h0001_0002));
    extWrite(2'd1, 32'h5C);
    extWrite(2'd0, 32'h3);
    waitBusy(1'b1, 10, "t6_busy_rise");
    checkOutput("t6_hold", {39'd0, hold_ctrl_o}, 40'd1);
    extWrite(2'd0, 32'hDEAD_0000);
    waitBusy(1'b0, 200, "t6_busy_fall");
    checkOutput("t6_ctrl_blocked", {8'd0, regs[0]}, 40'h0001_0002);
    checkOutput("t6_cs_after", {39'd0, cs_o}, 40'd0);
    checkOutput("t6_drained", 40'(expQ.size()), 40'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
